qarbiter_rr: RTL and testbench

//  Round-robin arbiter sharing one downstream DTI queue channel between NUM queue

---
 rtl/qarbiter_rr.sv | 81 ++++++++
 tb/tb_qarbiter_rr.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/qarbiter_rr.sv
// Round-robin arbiter merging NUM DTI queue producers onto one channel, locked per transaction.
// Define QARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-first priority.
module qarbiter_rr #(
  parameter int TDIN = 16,
  parameter int LVL  = 1,
  parameter int NUM  = 2,
  localparam int CTRL_W = $clog2(NUM)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM-1:0]                      din_valid,
  input  logic [NUM-1:0][LVL+TDIN-1:0]        din_data,
  output logic [NUM-1:0]                      din_ready,
  output logic                                dout_valid,
  output logic [CTRL_W+LVL+TDIN-1:0]          dout_data,
  input  logic                                dout_ready
);

  logic              lock_q;
  logic [CTRL_W-1:0] idx_q;
  logic [CTRL_W-1:0] ptr_q;

  logic              found;
  logic [CTRL_W-1:0] scan_sel;
  logic [CTRL_W-1:0] cand_idx;
  int                cand;
  logic [CTRL_W-1:0] sel;
  logic              have_sel;
  logic [LVL+TDIN-1:0] sel_item;
  logic              last;

  // Scan starts at ptr_q and wraps at NUM, so non-power-of-two NUM never aliases.
  always_comb begin
    found    = 1'b0;
    scan_sel = ptr_q;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NUM; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM) cand = cand - NUM;
      cand_idx = cand[CTRL_W-1:0];
      if (!found && din_valid[cand_idx]) begin
        found    = 1'b1;
        scan_sel = cand_idx;
      end
    end
  end

  always_comb begin
    sel        = lock_q ? idx_q : scan_sel;
    have_sel   = lock_q | found;
    sel_item   = din_data[sel];
    last       = &sel_item[TDIN +: LVL];
    dout_valid = rst & have_sel & din_valid[sel];
    dout_data  = {sel, sel_item};
    din_ready  = '0;
    if (rst && have_sel) din_ready[sel] = dout_ready;
  end

  // Any offered-but-unfinished item pins the selection, keeping dout stable while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_q <= 1'b0;
      idx_q  <= '0;
      ptr_q  <= '0;
    end else if (dout_valid) begin
      if (dout_ready && last) begin
        lock_q <= 1'b0;
`ifdef QARB_FIXED_PRIO_EN
        ptr_q  <= '0;
`else
        ptr_q  <= (sel == CTRL_W'(NUM-1)) ? '0 : sel + CTRL_W'(1);
`endif
      end else begin
        lock_q <= 1'b1;
        idx_q  <= sel;
      end
    end
  end

endmodule

// File: tb/tb_qarbiter_rr.sv
// Self-checking bench for qarbiter_rr: directed scenarios then random traffic vs. a transaction-level model.
module tb_qarbiter_rr;
  localparam int TDIN   = 8;
  localparam int LVL    = 2;
  localparam int NUM    = 3;
  localparam int CTRL_W = $clog2(NUM);
  localparam int DW     = LVL + TDIN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                        rst;
  logic [NUM-1:0]              din_valid;
  logic [NUM-1:0][DW-1:0]      din_data;
  logic [NUM-1:0]              din_ready;
  logic                        dout_valid;
  logic [CTRL_W+DW-1:0]        dout_data;
  logic                        dout_ready;

  qarbiter_rr #(.TDIN(TDIN), .LVL(LVL), .NUM(NUM)) dut (
    .clk(clk), .rst(rst),
    .din_valid(din_valid), .din_data(din_data), .din_ready(din_ready),
    .dout_valid(dout_valid), .dout_data(dout_data), .dout_ready(dout_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Producer-side offers and downstream/reset drive values.
  logic            item_valid [NUM];
  logic [LVL-1:0]  item_eot   [NUM];
  logic [TDIN-1:0] item_data  [NUM];
  logic            rst_drv;
  logic            ready_drv;

  // Model: current owner (-1 none) and where the next search begins.
  int              owner;
  int              start;
  logic            m_has, m_valid, m_last;
  int              m_sel;
  logic [NUM-1:0]  acc;
  logic [NUM-1:0]  exp_ready;
  logic [CTRL_W+DW-1:0] exp_data;

  task automatic set_item(input int i, input logic v, input logic [LVL-1:0] e);
    item_valid[i] = v;
    item_eot[i]   = e;
  endtask

  task automatic check_output();
    m_has = 1'b0;
    m_sel = 0;
    if (rst_drv) begin
      if (owner >= 0) begin
        m_has = 1'b1;
        m_sel = owner;
      end else begin
        for (int k = 0; k < NUM; k++) begin
          if (!m_has && item_valid[(start + k) % NUM]) begin
            m_has = 1'b1;
            m_sel = (start + k) % NUM;
          end
        end
      end
    end
    m_valid  = m_has && item_valid[m_sel];
    m_last   = (item_eot[m_sel] == {LVL{1'b1}});
    exp_data = {CTRL_W'(m_sel), item_eot[m_sel], item_data[m_sel]};
    for (int i = 0; i < NUM; i++) exp_ready[i] = m_has && ready_drv && (m_sel == i);

    checks++;
    assert (dout_valid === m_valid) else begin
      errors++;
      $error("[TB] FAIL dout_valid cyc=%0d got=%0b exp=%0b", cyc, dout_valid, m_valid);
    end
    checks++;
    assert (din_ready === exp_ready) else begin
      errors++;
      $error("[TB] FAIL din_ready cyc=%0d got=%b exp=%b", cyc, din_ready, exp_ready);
    end
    if (m_valid) begin
      checks++;
      assert (dout_data === exp_data) else begin
        errors++;
        $error("[TB] FAIL dout_data cyc=%0d got=%h exp=%h", cyc, dout_data, exp_data);
      end
    end
  endtask

  task automatic apply_stimulus();
    rst        = rst_drv;
    dout_ready = ready_drv;
    for (int i = 0; i < NUM; i++) begin
      din_valid[i] = item_valid[i];
      din_data[i]  = {item_eot[i], item_data[i]};
    end
    #1;
    check_output();
  endtask

  task automatic advance();
    acc = '0;
    if (!rst_drv) begin
      owner = -1;
      start = 0;
    end else if (m_valid) begin
      if (ready_drv) acc[m_sel] = 1'b1;
      if (ready_drv && m_last) begin
        owner = -1;
`ifdef QARB_FIXED_PRIO_EN
        start = 0;
`else
        start = (m_sel + 1) % NUM;
`endif
      end else begin
        owner = m_sel;
      end
    end
    for (int i = 0; i < NUM; i++) if (acc[i]) item_data[i] = TDIN'($urandom);
    @(negedge clk);
    cyc++;
  endtask

  // Optional exp_ctrl adds an explicit hand-derived grant-index check for this cycle.
  task automatic step(input int exp_ctrl = -1);
    apply_stimulus();
    if (exp_ctrl >= 0) begin
      checks++;
      assert ({dout_valid, dout_data[CTRL_W+DW-1 -: CTRL_W]} === {1'b1, CTRL_W'(exp_ctrl)}) else begin
        errors++;
        $error("[TB] FAIL ctrl cyc=%0d got valid=%0b ctrl=%0d exp valid=1 ctrl=%0d",
               cyc, dout_valid, dout_data[CTRL_W+DW-1 -: CTRL_W], exp_ctrl);
      end
    end
    advance();
  endtask

  initial begin
    owner     = -1;
    start     = 0;
    acc       = '0;
    rst_drv   = 1'b0;
    ready_drv = 1'b1;
    for (int i = 0; i < NUM; i++) begin
      item_valid[i] = 1'b1;
      item_eot[i]   = '1;
      item_data[i]  = TDIN'($urandom);
    end
    @(negedge clk);

    $display("[TB] reset with all inputs valid");
    step();
    step();
    rst_drv = 1'b1;

    $display("[TB] multi-beat transaction on din0 holds din1 off");
    set_item(2, 1'b0, 2'b11);
    set_item(1, 1'b1, 2'b11);
    set_item(0, 1'b1, 2'b01); step(0);
    set_item(0, 1'b1, 2'b10); step(0);
    set_item(0, 1'b1, 2'b11); step(0);
    set_item(0, 1'b0, 2'b11); step(1);

    $display("[TB] all inputs valid, single-item transactions");
    for (int i = 0; i < NUM; i++) set_item(i, 1'b1, 2'b11);
    for (int k = 0; k < 6; k++) begin
`ifdef QARB_FIXED_PRIO_EN
      step(0);
`else
      step((2 + k) % NUM);
`endif
    end

    $display("[TB] stalled offer stays stable");
    set_item(0, 1'b0, 2'b11);
    set_item(2, 1'b0, 2'b11);
    set_item(1, 1'b1, 2'b11);
    ready_drv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) set_item(0, 1'b1, 2'b11);
      step(1);
    end
    ready_drv = 1'b1;
    step(1);

    $display("[TB] owner pauses valid mid-transaction");
    set_item(1, 1'b1, 2'b11);
    set_item(0, 1'b1, 2'b00); step(0);
    set_item(0, 1'b0, 2'b00); step();
    step();
    set_item(0, 1'b1, 2'b11); step(0);
    set_item(0, 1'b0, 2'b11); step(1);

    $display("[TB] reset mid-transaction");
    set_item(1, 1'b1, 2'b00); step(1);
    rst_drv = 1'b0;
    set_item(0, 1'b1, 2'b11);
    set_item(1, 1'b1, 2'b11);
    step();
    rst_drv = 1'b1;
    step(0);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      rst_drv   = ($urandom_range(0, 99) != 0);
      ready_drv = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NUM; i++) begin
        if (!(item_valid[i] && !acc[i])) begin
          item_valid[i] = ($urandom_range(0, 9) < 6);
          item_eot[i]   = LVL'($urandom);
          item_data[i]  = TDIN'($urandom);
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
